// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM encoding and store-lane helpers for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    store_strb = 4'b0001 << offset;
      F3_H:    store_strb = offset[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] rs2);
    case (funct3)
      F3_B:    store_data = {4{rs2[7:0]}};
      F3_H:    store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port shared by the access unit and the memory model.
interface mem_access_unit_if #(
  parameter int addrWidth = 15
);
  logic                 dm_req;
  logic                 dm_we;
  logic [addrWidth-1:0] dm_addr;
  logic [3:0]           dm_wstrb;
  logic [31:0]          dm_wdata;
  logic                 dm_ack;
  logic [31:0]          dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (offset)
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      2'd3:    lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    result = {{16{lane_half[15]}}, lane_half};
      F3_BU:   result = {24'd0, lane_byte};
      F3_HU:   result = {16'd0, lane_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: decodes RV32I loads/stores, runs one req/ack
// transaction at a time and stalls the pipeline until it completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int addrWidth = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [31:0]          inst_in,
  input  logic [31:0]          alu_out_in,
  input  logic [31:0]          rs2_data_in,
  mem_access_unit_if.master    dm,
  output logic                 mem_stall,
  output logic [31:0]          ld_data,
  output logic                 misaligned
);

  state_t      state;
  state_t      state_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        half_access;
  logic        word_access;
  logic        mis_access;
  logic        issue;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] load_result;
  logic        unused_bits;

  assign opcode      = inst_in[6:0];
  assign funct3      = inst_in[14:12];
  assign is_load     = valid_in && (opcode == OP_LOAD) &&
                       (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign is_store    = valid_in && (opcode == OP_STORE) &&
                       (funct3 inside {F3_B, F3_H, F3_W});
  assign mem_op      = is_load || is_store;
  assign half_access = (funct3[1:0] == 2'b01);
  assign word_access = (funct3[1:0] == 2'b10);
  assign mis_access  = mem_op && ((half_access && alu_out_in[0]) ||
                                  (word_access && (alu_out_in[1:0] != 2'b00)));
  assign issue       = mem_op && !mis_access;
  assign unused_bits = ^{inst_in[31:15], inst_in[11:7], alu_out_in[31:addrWidth]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (issue) state_next = S_WAIT;
      S_WAIT:  if (dm.dm_ack) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stall is raised in the detect cycle itself so the instruction cannot slip past.
  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) mem_stall = ((state == S_IDLE) && issue) || (state == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wstrb <= 4'b0000;
      dm.dm_wdata <= 32'd0;
      ld_data     <= 32'd0;
      misaligned  <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      misaligned <= (state == S_IDLE) && mis_access;
      if ((state == S_IDLE) && issue) begin
        dm.dm_req   <= 1'b1;
        dm.dm_we    <= is_store;
        dm.dm_addr  <= {alu_out_in[addrWidth-1:2], 2'b00};
        dm.dm_wstrb <= is_store ? store_strb(funct3, alu_out_in[1:0]) : 4'b0000;
        dm.dm_wdata <= store_data(funct3, rs2_data_in);
        f3_q        <= funct3;
        off_q       <= alu_out_in[1:0];
      end else if ((state == S_WAIT) && dm.dm_ack) begin
        dm.dm_req <= 1'b0;
        if (!dm.dm_we) ld_data <= load_result;
      end
    end
  end

  mem_load_align u_load_align (
    .rdata  (dm.dm_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_result)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized instructions
// scored against a byte-address-level model of loads, stores and stall length.
module tb_mem_access_unit;

  localparam int addrWidth = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] inst_in = 32'd0;
  logic [31:0] alu_out_in = 32'd0;
  logic [31:0] rs2_data_in = 32'd0;
  logic        mem_stall;
  logic [31:0] ld_data;
  logic        misaligned;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ld = 32'd0;

  mem_access_unit_if #(.addrWidth(addrWidth)) dmif ();

  mem_access_unit #(.addrWidth(addrWidth)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .inst_in     (inst_in),
    .alu_out_in  (alu_out_in),
    .rs2_data_in (rs2_data_in),
    .dm          (dmif),
    .mem_stall   (mem_stall),
    .ld_data     (ld_data),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  // Classification: 0 = no access, 1 = misaligned, 2 = load, 3 = store.
  function automatic int opClass(input logic v, input logic [31:0] inst, input logic [31:0] addr);
    logic [6:0] op;
    logic [2:0] f3;
    bit         ld;
    bit         st;
    int         size;
    op = inst[6:0];
    f3 = inst[14:12];
    ld = v && (op == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    st = v && (op == 7'h23) && (f3 == 0 || f3 == 1 || f3 == 2);
    if (!(ld || st)) return 0;
    size = 1 << f3[1:0];
    if ((addr % size) != 0) return 1;
    return ld ? 2 : 3;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] word, input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> (8 * off);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int          n;
    n = 1 << f3[1:0];
    w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] makeInst(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF8F80) | {17'd0, f3, 12'd0} | {25'd0, op};
  endfunction

  // Presents one instruction (called just after a rising edge) and follows it to completion.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata, input int ack_delay);
    int          cls;
    int          stalls;
    int          idx;
    bit          first;
    bit          done;
    logic [2:0]  f3;
    logic [31:0] strb;
    cls = opClass(v, inst, addr);
    f3  = inst[14:12];
    valid_in = v;
    inst_in = inst;
    alu_out_in = addr;
    rs2_data_in = rs2;
    if (cls < 2) begin
      @(negedge clk);
      checkOutput("idleStall", 32'(mem_stall), 32'd0);
      checkOutput("idleReq", 32'(dmif.dm_req), 32'd0);
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      checkOutput("misPulse", 32'(misaligned), (cls == 1) ? 32'd1 : 32'd0);
      checkOutput("noReq", 32'(dmif.dm_req), 32'd0);
      checkOutput("ldHold", ld_data, exp_ld);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("misClear", 32'(misaligned), 32'd0);
      @(posedge clk); #1;
    end else begin
      stalls = 0;
      idx = 0;
      first = 1'b1;
      done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        @(negedge clk);
        if (!mem_stall) done = 1'b1;
        else begin
          stalls++;
          if (dmif.dm_req) begin
            if (first) begin
              first = 1'b0;
              strb = (cls == 3) ? ((((32'd1 << (1 << f3[1:0])) - 1) << addr[1:0]) & 32'hF) : 32'd0;
              checkOutput("reqWe", 32'(dmif.dm_we), (cls == 3) ? 32'd1 : 32'd0);
              checkOutput("reqAddr", 32'(dmif.dm_addr), addr & 32'h7FFC);
              checkOutput("reqStrb", 32'(dmif.dm_wstrb), strb);
              if (cls == 3) checkOutput("reqWdata", dmif.dm_wdata, modelWdata(f3, rs2));
            end
            if (idx == ack_delay) begin
              dmif.dm_ack = 1'b1;
              dmif.dm_rdata = rdata;
            end
            idx++;
          end
          @(posedge clk); #1;
          dmif.dm_ack = 1'b0;
          dmif.dm_rdata = $urandom();
        end
      end
      if (cls == 2) exp_ld = modelLoad(f3, rdata, addr[1:0]);
      checkOutput("stallCycles", 32'(stalls), 32'(ack_delay + 2));
      checkOutput("reqSeen", 32'(first), 32'd0);
      checkOutput("doneReq", 32'(dmif.dm_req), 32'd0);
      checkOutput("ldData", ld_data, exp_ld);
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      checkOutput("noReissue", 32'(dmif.dm_req), 32'd0);
      checkOutput("postStall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic resetDuringWait();
    valid_in = 1'b1;
    inst_in = makeInst(7'h03, 3'd2);
    alu_out_in = 32'h0000_0200;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstPreReq", 32'(dmif.dm_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstReq", 32'(dmif.dm_req), 32'd0);
    checkOutput("rstStall", 32'(mem_stall), 32'd0);
    checkOutput("rstAddr", 32'(dmif.dm_addr), 32'd0);
    checkOutput("rstStrb", 32'(dmif.dm_wstrb), 32'd0);
    checkOutput("rstLd", ld_data, 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ld = 32'd0;
    @(posedge clk); #1;
    dmif.dm_ack = 1'b1;
    dmif.dm_rdata = 32'h0000_0001;
    @(posedge clk); #1;
    dmif.dm_ack = 1'b0;
    @(negedge clk);
    checkOutput("strayAckLd", ld_data, 32'd0);
    checkOutput("strayAckReq", 32'(dmif.dm_req), 32'd0);
    checkOutput("strayAckStall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0]  op;
    logic [31:0] r;
    dmif.dm_ack = 1'b0;
    dmif.dm_rdata = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetReq", 32'(dmif.dm_req), 32'd0);
    checkOutput("resetWe", 32'(dmif.dm_we), 32'd0);
    checkOutput("resetWdata", dmif.dm_wdata, 32'd0);
    checkOutput("resetLd", ld_data, 32'd0);
    checkOutput("resetMis", 32'(misaligned), 32'd0);
    checkOutput("resetStall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b1, makeInst(7'h03, 3'd2), 32'h0000_0100, 32'd0, 32'hDEADBEEF, 2);
    checkOutput("lwLiteral", ld_data, 32'hDEADBEEF);
    applyStimulus(1'b1, makeInst(7'h03, 3'd0), 32'h0000_0103, 32'd0, 32'h80FF_FF00, 0);
    checkOutput("lbLiteral", ld_data, 32'hFFFF_FF80);
    applyStimulus(1'b1, makeInst(7'h03, 3'd4), 32'h0000_0103, 32'd0, 32'h80FF_FF00, 0);
    checkOutput("lbuLiteral", ld_data, 32'h0000_0080);
    applyStimulus(1'b1, makeInst(7'h23, 3'd1), 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
    checkOutput("shLdKept", ld_data, 32'h0000_0080);
    applyStimulus(1'b1, makeInst(7'h23, 3'd0), 32'h0000_0101, 32'h0000_00A5, 32'h0, 0);
    applyStimulus(1'b1, makeInst(7'h03, 3'd5), 32'h0000_0102, 32'd0, 32'hF00D_1234, 1);
    checkOutput("lhuLiteral", ld_data, 32'h0000_F00D);
    applyStimulus(1'b1, makeInst(7'h03, 3'd2), 32'h0000_0101, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, makeInst(7'h03, 3'd1), 32'h0000_0103, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, makeInst(7'h33, 3'd0), 32'h0000_0100, 32'd0, 32'd0, 0);
    applyStimulus(1'b0, makeInst(7'h03, 3'd2), 32'h0000_0100, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, makeInst(7'h03, 3'd3), 32'h0000_0100, 32'd0, 32'd0, 0);

    resetDuringWait();

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0:       op = 7'h03;
        1:       op = 7'h23;
        2:       op = 7'h33;
        default: begin r = $urandom(); op = r[6:0]; end
      endcase
      applyStimulus($urandom_range(0, 7) != 0, makeInst(op, 3'($urandom_range(0, 7))),
                    $urandom(), $urandom(), $urandom(), $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit between the EX/MEM stage register and Reg_WB.
- Decodes RV32I loads and stores from the MEM-stage instruction and drives a variable-latency req/ack data-memory port.
- Stalls the pipeline while an access is outstanding.
- Produces aligned, sign- or zero-extended load data that Reg_WB captures as ld_data_in.

Parameters:
addrWidth, 15, data-memory byte-address width; dm_addr = alu_out_in[addrWidth-1:0] with bits [1:0] forced to 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  MEM-stage instruction is valid (not a bubble)
inst_in  in  32  MEM-stage instruction
alu_out_in  in  32  effective byte address (rs1+imm)
rs2_data_in  in  32  store source data
dm_req  out  1  memory request, registered
dm_we  out  1  1=store, 0=load, registered
dm_addr  out  addrWidth  word-aligned byte address, registered
dm_wstrb  out  4  byte write strobes, registered (0 for loads)
dm_wdata  out  32  lane-replicated store data, registered
dm_ack  in  1  memory completion, single-cycle pulse
dm_rdata  in  32  read word, valid with dm_ack
mem_stall  out  1  freeze upstream pipeline and Reg_WB (drives Stall)
ld_data  out  32  extended load result, registered
misaligned  out  1  one-cycle pulse on misaligned access, registered

Behaviour:
- Mem op: valid_in=1 and either:
  - opcode 0000011 with funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}, or
  - opcode 0100011 with funct3 in {000 SB, 001 SH, 010 SW}.
- Any other funct3, opcode, or valid_in=0: no access and no stall.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No request, no stall.
  - misaligned=1 for the next cycle.
  - ld_data unchanged.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an aligned mem op: mem_stall=1 combinationally. On the next edge, register dm_req=1, dm_we, dm_addr, dm_wstrb, dm_wdata, and latch funct3 and addr[1:0]; go to WAIT.
  - Otherwise: mem_stall=0.
- WAIT:
  - mem_stall=1 and dm_req held high with stable attributes.
  - On dm_ack=1: for a load, register the extended result into ld_data; clear dm_req; go to DONE. The ack may arrive in the first WAIT cycle.
- DONE:
  - mem_stall=0 for exactly one cycle, so the pipeline advances and Reg_WB captures ld_data.
  - Go to IDLE unconditionally. The instruction seen in DONE is never re-issued.
- Latency: minimum 2 stall cycles (IDLE-detect + one WAIT). Each extra WAIT cycle adds one stall cycle.
- dm_ack outside WAIT is ignored.
- Store data and strobes:
  - SB: wdata = rs2[7:0] replicated x4; wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = rs2[15:0] replicated x2; wstrb = 0011 if addr[1]=0, else 1100.
  - SW: wdata = rs2; wstrb = 1111.
- Load extraction from dm_rdata uses the latched addr[1:0]:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store completion leaves ld_data unchanged.
- Reset (rst_n=0, asynchronous, including mid-WAIT):
  - State=IDLE.
  - dm_req=0, dm_we=0, dm_addr=0, dm_wstrb=0, dm_wdata=0, ld_data=0, misaligned=0.
  - mem_stall=0 while in reset. A pending ack after reset is ignored.
- Only one access is outstanding at a time. The memory must hold dm_rdata valid only during the dm_ack cycle.

Decomposition:
- Shared package holds:
  - opcode constants OP_LOAD and OP_STORE;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state encoding (2-bit).
- One natural sub-module, mem_load_align: combinational, takes rdata, offset[1:0], funct3 and returns the extended 32-bit result. It is reused by any future load path.

Test Plan:
- LW at 0x0100, ack 3 cycles after req, rdata 0xDEADBEEF -> 4 stall cycles, then ld_data=0xDEADBEEF, mem_stall=0 for one cycle, no second req.
- LB at 0x0103, ack in first WAIT cycle, rdata 0x80FF_FF00 -> ld_data=0xFFFFFF80. Repeat as LBU -> 0x00000080. Total 2 stall cycles.
- SH at 0x0102, rs2=0x1234ABCD -> dm_we=1, dm_addr=0x0100, dm_wstrb=1100, dm_wdata=0xABCDABCD; ld_data unchanged.
- SB at 0x0101, rs2=0x000000A5 -> dm_wstrb=0010, dm_wdata=0xA5A5A5A5.
- LW at 0x0101 -> misaligned=1 for one cycle, dm_req stays 0, mem_stall stays 0. Also: ADD, or valid_in=0 with a load opcode -> no req, no stall.
- rst_n low during WAIT -> dm_req=0 immediately, state IDLE. A later stray dm_ack with rdata 0x1 leaves ld_data=0.
